// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: encode requests in, address-tagged words out.
// master = request producer / word consumer, slave = the encoder itself.
// Both directions use valid/ready; err/err_id are sticky status from the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_id;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [5:0]        err_id;

  modport master (
    output in_valid, in_id, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, err_id
  );

  modport slave (
    input  in_valid, in_id, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, err_id
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: turns (id, rs, rt, rd, shamt, imm) requests into 32-bit MIPS words, queued in a
// DEPTH-entry FIFO and tagged with their instruction-memory word address (BASE_ADDR + pops).
// Latency 1 cycle to FIFO head; in_ready = !full. Optional macro ENC_RANGE_CHECK_EN drops out-of-range immediates.
module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Field layout classes; each class fixes which operand fields land in the word.
  typedef enum logic [3:0] {
    C_RREG,    // rs, rt, rd, funct
    C_SHIFT,   // rt, rd, shamt, funct
    C_JR,      // rs, funct
    C_JALR,    // rs, rd, funct
    C_REGIMM,  // op=1, rs, rt=code, imm16
    C_BZ,      // op, rs, rt=0, imm16
    C_LUI,     // op, rs=0, rt, imm16
    C_ITYPE,   // op, rs, rt, imm16
    C_JUMP,    // op, target26
    C_BAD      // unknown id
  } cls_e;

  cls_e        cls;
  logic [5:0]  code;     // funct for R-type, opcode otherwise, rt value for REGIMM
  logic        id_ok;
  logic        imm_ok;
  logic [31:0] word;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [5:0]        err_id_q, err_id_d;

  logic full, empty, accept, push, pop, reject;

  // True when imm fits the field the given id places it in.
  function automatic logic imm_fits(input logic [5:0] id, input logic [31:0] imm);
    logic fits;
    fits = 1'b1;
    case (id)
      6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd30:
        fits = (imm[31:16] == 16'd0);
      6'd16, 6'd17, 6'd18, 6'd19, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd31, 6'd32, 6'd33:
        fits = (imm[31:15] == 17'd0) || (imm[31:15] == 17'h1ffff);
      6'd34, 6'd35:
        fits = (imm[31:26] == 6'd0);
      default:
        fits = 1'b1;
    endcase
    return fits;
  endfunction

  // Map the instruction id to its field layout class and opcode/funct code.
  always_comb begin
    cls  = C_BAD;
    code = 6'd0;
    case (bus.in_id)
      6'd0:  begin cls = C_RREG;   code = 6'h21; end  // addu
      6'd1:  begin cls = C_RREG;   code = 6'h23; end  // subu
      6'd2:  begin cls = C_RREG;   code = 6'h24; end  // and
      6'd3:  begin cls = C_RREG;   code = 6'h25; end  // or
      6'd4:  begin cls = C_RREG;   code = 6'h26; end  // xor
      6'd5:  begin cls = C_RREG;   code = 6'h27; end  // nor
      6'd6:  begin cls = C_RREG;   code = 6'h2a; end  // slt
      6'd7:  begin cls = C_RREG;   code = 6'h2b; end  // sltu
      6'd8:  begin cls = C_SHIFT;  code = 6'h00; end  // sll
      6'd9:  begin cls = C_SHIFT;  code = 6'h02; end  // srl
      6'd10: begin cls = C_SHIFT;  code = 6'h03; end  // sra
      6'd11: begin cls = C_RREG;   code = 6'h04; end  // sllv
      6'd12: begin cls = C_RREG;   code = 6'h06; end  // srlv
      6'd13: begin cls = C_RREG;   code = 6'h07; end  // srav
      6'd14: begin cls = C_JR;     code = 6'h08; end  // jr
      6'd15: begin cls = C_JALR;   code = 6'h09; end  // jalr
      6'd16: begin cls = C_REGIMM; code = 6'h01; end  // bgez (rt=1)
      6'd17: begin cls = C_REGIMM; code = 6'h00; end  // bltz (rt=0)
      6'd18: begin cls = C_ITYPE;  code = 6'h09; end  // addiu
      6'd19: begin cls = C_ITYPE;  code = 6'h0a; end  // slti
      6'd20: begin cls = C_ITYPE;  code = 6'h0b; end  // sltiu
      6'd21: begin cls = C_ITYPE;  code = 6'h0c; end  // andi
      6'd22: begin cls = C_ITYPE;  code = 6'h0d; end  // ori
      6'd23: begin cls = C_ITYPE;  code = 6'h0e; end  // xori
      6'd24: begin cls = C_LUI;    code = 6'h0f; end  // lui
      6'd25: begin cls = C_ITYPE;  code = 6'h04; end  // beq
      6'd26: begin cls = C_ITYPE;  code = 6'h05; end  // bne
      6'd27: begin cls = C_BZ;     code = 6'h06; end  // blez
      6'd28: begin cls = C_BZ;     code = 6'h07; end  // bgtz
      6'd29: begin cls = C_ITYPE;  code = 6'h20; end  // lb
      6'd30: begin cls = C_ITYPE;  code = 6'h24; end  // lbu
      6'd31: begin cls = C_ITYPE;  code = 6'h28; end  // sb
      6'd32: begin cls = C_ITYPE;  code = 6'h23; end  // lw
      6'd33: begin cls = C_ITYPE;  code = 6'h2b; end  // sw
      6'd34: begin cls = C_JUMP;   code = 6'h02; end  // j
      6'd35: begin cls = C_JUMP;   code = 6'h03; end  // jal
      default: begin cls = C_BAD;  code = 6'h00; end
    endcase
  end

  // Assemble the word; fields a class does not use stay zero.
  always_comb begin
    word = 32'd0;
    case (cls)
      C_RREG:   word = {6'd0, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, code};
      C_SHIFT:  word = {6'd0, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, code};
      C_JR:     word = {6'd0, bus.in_rs, 15'd0, code};
      C_JALR:   word = {6'd0, bus.in_rs, 5'd0, bus.in_rd, 5'd0, code};
      C_REGIMM: word = {6'd1, bus.in_rs, code[4:0], bus.in_imm[15:0]};
      C_BZ:     word = {code, bus.in_rs, 5'd0, bus.in_imm[15:0]};
      C_LUI:    word = {code, 5'd0, bus.in_rt, bus.in_imm[15:0]};
      C_ITYPE:  word = {code, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      C_JUMP:   word = {code, bus.in_imm[25:0]};
      default:  word = 32'd0;
    endcase
  end

  assign id_ok = (cls != C_BAD);

`ifdef ENC_RANGE_CHECK_EN
  // Out-of-range immediates are treated like unknown ids: accepted, dropped, flagged.
  assign imm_ok = imm_fits(bus.in_id, bus.in_imm);
`else
  // Immediates are silently truncated to their field; upper bits only matter with range checking.
  logic imm_hi_unused;
  assign imm_ok        = 1'b1;
  assign imm_hi_unused = ^bus.in_imm[31:26];
`endif

  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign accept = bus.in_valid & ~full;
  assign push   = accept & id_ok & imm_ok;
  assign reject = accept & ~(id_ok & imm_ok);
  assign pop    = ~empty & bus.out_ready;

  // Next-state for FIFO storage, pointers, address tag and sticky error capture.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_q] = word;
    end
    wr_d     = wr_q + PTR_W'(push);
    rd_d     = rd_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    addr_d   = addr_q + ADDR_W'(pop);
    err_d    = err_q | reject;
    err_id_d = (reject && !err_q) ? bus.in_id : err_id_q;
  end

  // Control state registers; reset empties the FIFO and restarts addressing.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
      err_id_q <= 6'd0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  // Word storage; stale entries are never visible because out_instr is gated by empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_instr = empty ? 32'd0 : mem_q[rd_q];
  assign bus.out_addr  = addr_q;
  assign bus.err       = err_q;
  assign bus.err_id    = err_id_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed encoding vectors, hand-written back-pressure / error / reset
// sequences, and a long random run against a queue-based reference model.
// A second instance with ADDR_W=2 shares the stimulus to exercise address wrap.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int AWW   = 2;
`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  // funct codes for ids 0..15, opcodes for ids 18..33 (decimal on purpose)
  localparam int RFN [16] = '{33, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8, 9};
  localparam int IOP [16] = '{9, 10, 11, 12, 13, 14, 15, 4, 5, 6, 7, 32, 36, 40, 35, 43};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(AW))  bus_m ();
  instr_encoder_if #(.ADDR_W(AWW)) bus_w ();

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR('0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(AWW), .BASE_ADDR('0)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  assign bus_w.in_valid  = bus_m.in_valid;
  assign bus_w.in_id     = bus_m.in_id;
  assign bus_w.in_rs     = bus_m.in_rs;
  assign bus_w.in_rt     = bus_m.in_rt;
  assign bus_w.in_rd     = bus_m.in_rd;
  assign bus_w.in_shamt  = bus_m.in_shamt;
  assign bus_w.in_imm    = bus_m.in_imm;
  assign bus_w.out_ready = bus_m.out_ready;

  // reference model state
  logic [31:0] mq[$];
  int unsigned pops;
  bit          m_err;
  logic [5:0]  m_err_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [5:0]  id;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit ref_fits(input int id, input int imm);
    if (id inside {20, 21, 22, 23, 24, 30}) return (imm >= 0) && (imm <= 65535);
    if (id inside {16, 17, 18, 19, 25, 26, 27, 28, 29, 31, 32, 33})
      return (imm >= -32768) && (imm <= 32767);
    if (id inside {34, 35}) return (imm >= 0) && (imm < 2**26);
    return 1'b1;
  endfunction

  // Returns 1 and the encoded word if the request would be pushed.
  function automatic bit ref_encode(input int id, input int rs, input int rt, input int rd,
                                    input int sh, input int imm, output logic [31:0] w);
    longint t, op, lo16, tgt;
    w = 32'd0;
    if (id > 35) return 1'b0;
    if (RC && !ref_fits(id, imm)) return 1'b0;
    lo16 = ((longint'(imm) % 65536) + 65536) % 65536;
    tgt  = ((longint'(imm) % 2**26) + 2**26) % 2**26;
    t    = 0;
    if (id <= 15) begin
      t = RFN[id];
      if (!(id >= 8 && id <= 10)) t += longint'(rs) * 2**21;
      if (id != 14 && id != 15)   t += longint'(rt) * 2**16;
      if (id != 14)               t += longint'(rd) * 2**11;
      if (id >= 8 && id <= 10)    t += longint'(sh) * 64;
    end else if (id == 16 || id == 17) begin
      t = 2**26 + longint'(rs) * 2**21 + ((id == 16) ? 2**16 : 0) + lo16;
    end else if (id <= 33) begin
      op = IOP[id-18];
      t  = op * 2**26 + lo16;
      if (id != 24)             t += longint'(rs) * 2**21;
      if (id != 27 && id != 28) t += longint'(rt) * 2**16;
    end else begin
      t = ((id == 34) ? 2 : 3) * longint'(2**26) + tgt;
    end
    w = t[31:0];
    return 1'b1;
  endfunction

  // Drive one cycle (called #1 after a rising edge), check outputs against the model, advance.
  task automatic step(input bit v, input logic [5:0] id, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm,
                      input bit ordy, output bit acc);
    logic [31:0] w;
    bit ok;
    bus_m.in_valid  = v;
    bus_m.in_id     = id;
    bus_m.in_rs     = rs;
    bus_m.in_rt     = rt;
    bus_m.in_rd     = rd;
    bus_m.in_shamt  = sh;
    bus_m.in_imm    = imm;
    bus_m.out_ready = ordy;
    chk("out_valid", 32'(bus_m.out_valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(bus_m.in_ready), 32'(mq.size() < DEPTH));
    chk("out_instr", bus_m.out_instr, (mq.size() != 0) ? mq[0] : 32'd0);
    chk("out_addr", 32'(bus_m.out_addr), pops % (1 << AW));
    chk("wrap_addr", 32'(bus_w.out_addr), pops % (1 << AWW));
    chk("err", 32'(bus_m.err), 32'(m_err));
    chk("err_id", 32'(bus_m.err_id), 32'(m_err_id));
    acc = v && (mq.size() < DEPTH);
    if (ordy && mq.size() != 0) begin
      void'(mq.pop_front());
      pops++;
    end
    if (acc) begin
      ok = ref_encode(int'(id), int'(rs), int'(rt), int'(rd), int'(sh), int'($signed(imm)), w);
      if (ok) mq.push_back(w);
      else if (!m_err) begin
        m_err    = 1'b1;
        m_err_id = id;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    step(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, ordy, acc);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus_m.in_valid   = 1'b0;
    bus_m.in_id      = 6'd0;
    bus_m.in_rs      = 5'd0;
    bus_m.in_rt      = 5'd0;
    bus_m.in_rd      = 5'd0;
    bus_m.in_shamt   = 5'd0;
    bus_m.in_imm     = 32'd0;
    bus_m.out_ready  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    pops     = 0;
    m_err    = 1'b0;
    m_err_id = 6'd0;
  endtask

  vec_t vecs [17];
  logic [31:0] seen_m [8];
  logic [31:0] seen_w [8];

  initial begin
    bit acc;
    bit held_acc;
    int n;

    vecs[0]  = '{"addu",   6'd0,  5'd1,  5'd2,  5'd3,  5'd0, 32'h0,        32'h00221821};
    vecs[1]  = '{"addiu",  6'd18, 5'd0,  5'd8,  5'd0,  5'd0, 32'hffffffff, 32'h2408ffff};
    vecs[2]  = '{"lui",    6'd24, 5'd0,  5'd1,  5'd0,  5'd0, 32'h1001,     32'h3c011001};
    vecs[3]  = '{"bgez",   6'd16, 5'd4,  5'd0,  5'd0,  5'd0, 32'd3,        32'h04810003};
    vecs[4]  = '{"jal",    6'd35, 5'd0,  5'd0,  5'd0,  5'd0, 32'h100000,   32'h0c100000};
    vecs[5]  = '{"sll",    6'd8,  5'd7,  5'd2,  5'd4,  5'd3, 32'h0,        32'h000220c0};
    vecs[6]  = '{"jr",     6'd14, 5'd31, 5'd5,  5'd6,  5'd1, 32'h0,        32'h03e00008};
    vecs[7]  = '{"jalr",   6'd15, 5'd4,  5'd3,  5'd31, 5'd0, 32'h0,        32'h0080f809};
    vecs[8]  = '{"bltz",   6'd17, 5'd2,  5'd7,  5'd0,  5'd0, 32'hfffffffe, 32'h0440fffe};
    vecs[9]  = '{"beq",    6'd25, 5'd1,  5'd2,  5'd0,  5'd0, 32'd5,        32'h10220005};
    vecs[10] = '{"sw",     6'd33, 5'd29, 5'd31, 5'd0,  5'd0, 32'd8,        32'hafbf0008};
    vecs[11] = '{"nor",    6'd5,  5'd1,  5'd2,  5'd3,  5'd5, 32'h0,        32'h00221827};
    vecs[12] = '{"blez",   6'd27, 5'd3,  5'd9,  5'd0,  5'd0, 32'h10,       32'h18600010};
    vecs[13] = '{"srav",   6'd13, 5'd5,  5'd6,  5'd7,  5'd9, 32'h0,        32'h00a63807};
    vecs[14] = '{"lui_rs", 6'd24, 5'd3,  5'd1,  5'd4,  5'd0, 32'h1001,     32'h3c011001};
    vecs[15] = '{"j_max",  6'd34, 5'd7,  5'd0,  5'd0,  5'd0, 32'h03ffffff, 32'h0bffffff};
    vecs[16] = '{"sltiu",  6'd20, 5'd2,  5'd3,  5'd0,  5'd0, 32'hffff,     32'h2c43ffff};

    // reset state
    do_reset();
    chk("rst_in_ready", 32'(bus_m.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus_m.out_valid), 32'd0);
    chk("rst_out_instr", bus_m.out_instr, 32'd0);
    chk("rst_out_addr", 32'(bus_m.out_addr), 32'd0);
    chk("rst_err", 32'(bus_m.err), 32'd0);
    chk("rst_err_id", 32'(bus_m.err_id), 32'd0);

    // fixed encodings, one request at a time, head popped the following cycle
    for (int i = 0; i < 17; i++) begin
      step(1'b1, vecs[i].id, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, 1'b1, acc);
      chk({"vec_", vecs[i].name}, bus_m.out_instr, vecs[i].exp);
      chk({"vec_addr_", vecs[i].name}, 32'(bus_m.out_addr), 32'(i));
      idle(1'b1);
    end

    // back-pressure: 4 fill the FIFO, 5th held until space appears
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 6'd0, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 32'd0, 1'b0, acc);
    end
    chk("bp_full_in_ready", 32'(bus_m.in_ready), 32'd0);
    step(1'b1, 6'd1, 5'd9, 5'd9, 5'd9, 5'd0, 32'd0, 1'b0, held_acc);
    chk("bp_still_full", 32'(bus_m.in_ready), 32'd0);
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      if (bus_m.out_valid) begin
        seen_m[n] = 32'(bus_m.out_addr);
        seen_w[n] = 32'(bus_w.out_addr);
        n++;
      end
      step(!held_acc, 6'd1, 5'd9, 5'd9, 5'd9, 5'd0, 32'd0, 1'b1, acc);
      held_acc = held_acc | acc;
    end
    chk("bp_pop_count", 32'(n), 32'd5);
    for (int k = 0; k < n; k++) begin
      chk("bp_addr_order", seen_m[k], 32'(k));
      chk("wrap_addr_seq", seen_w[k], 32'(k % 4));
    end

    // bad ids: first error latches, later ones do not overwrite
    step(1'b1, 6'd40, 5'd1, 5'd1, 5'd1, 5'd0, 32'd0, 1'b1, acc);
    chk("bad_err", 32'(bus_m.err), 32'd1);
    chk("bad_err_id", 32'(bus_m.err_id), 32'd40);
    chk("bad_not_pushed", 32'(bus_m.out_valid), 32'd0);
    step(1'b1, 6'd41, 5'd1, 5'd1, 5'd1, 5'd0, 32'd0, 1'b1, acc);
    idle(1'b0);
    chk("bad_err_id_sticky", 32'(bus_m.err_id), 32'd40);

    // ori with an immediate one past the zero-extended range
    do_reset();
    step(1'b1, 6'd22, 5'd0, 5'd0, 5'd0, 5'd0, 32'h10000, 1'b0, acc);
    chk("range_out_valid", 32'(bus_m.out_valid), RC ? 32'd0 : 32'd1);
    chk("range_instr", bus_m.out_instr, RC ? 32'd0 : 32'h34000000);
    chk("range_err", 32'(bus_m.err), 32'(RC));
    idle(1'b1);

    // reset with words queued and an error pending
    do_reset();
    step(1'b1, 6'd45, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 6'd3, 5'(i), 5'd2, 5'd3, 5'd0, 32'd0, 1'b0, acc);
    end
    idle(1'b1);
    do_reset();
    chk("rst_mid_out_valid", 32'(bus_m.out_valid), 32'd0);
    chk("rst_mid_out_addr", 32'(bus_m.out_addr), 32'd0);
    chk("rst_mid_err", 32'(bus_m.err), 32'd0);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] imm;
      if ($urandom_range(0, 399) == 0) do_reset();
      case ($urandom_range(0, 3))
        0:       imm = 32'($urandom_range(0, 70000));
        1:       imm = 32'(-int'($urandom_range(0, 40000)));
        2:       imm = 32'($urandom_range(0, 2**26 + 100));
        default: imm = $urandom();
      endcase
      step($urandom_range(0, 3) != 0, 6'($urandom_range(0, 39)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           imm, $urandom_range(0, 2) != 0, acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
